float_class_pipe: RTL and testbench

- Parametrised, pipelined IEEE-754 special-case classifier for the float<->fixed converters.
- Accepts one float per handshake on a valid/ready interface.
- Produces a one-hot class (zero/subnormal/normal/inf/qNaN/sNaN), the sign, and the legacy zero/normal/exception flags.
- Keeps sticky exception flags and a saturating exception counter for status readback.
- Sits between the input FIFO and the float-to-fixed datapath; backpressure propagates through it.

---
 rtl/float_class_pipe.sv | 191 +++++++++++++++++++
 tb/tb_float_class_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/float_class_pipe.sv
// Two-stage IEEE-754 special-case classifier with valid/ready flow control,
// sticky exception flags and a saturating exception counter.
module float_class_pipe #(
    parameter int EXPONENTBITS = 8,
    parameter int MANTISSABITS = 23,
    localparam int FLOATSIZE = EXPONENTBITS + MANTISSABITS + 1,
    parameter int CNTBITS = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [FLOATSIZE-1:0] InFloat,
    input  logic                 InDaz,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic                 OutSign,
    output logic [5:0]           OutClass,
    output logic                 OutZero,
    output logic                 OutNormal,
    output logic                 OutException,
    input  logic                 FlagClr,
    output logic                 FlagInvalid,
    output logic                 FlagInf,
    output logic                 FlagDenorm,
    output logic [CNTBITS-1:0]   ExcCount
);

    localparam logic [5:0] CLS_ZERO = 6'b000001;
    localparam logic [5:0] CLS_SUB  = 6'b000010;
    localparam logic [5:0] CLS_NORM = 6'b000100;
    localparam logic [5:0] CLS_INF  = 6'b001000;
    localparam logic [5:0] CLS_QNAN = 6'b010000;
    localparam logic [5:0] CLS_SNAN = 6'b100000;

    function automatic logic [5:0] classify(
        input logic [EXPONENTBITS-1:0] e,
        input logic [MANTISSABITS-1:0] m,
        input logic                    daz
    );
        logic [5:0] c;
        if (e == '0) begin
            c = ((m == '0) || daz) ? CLS_ZERO : CLS_SUB;
        end else if (&e) begin
            if (m == '0)                  c = CLS_INF;
            else if (m[MANTISSABITS-1])   c = CLS_QNAN;
            else                          c = CLS_SNAN;
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

    function automatic logic [CNTBITS-1:0] sat_inc(input logic [CNTBITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                    s1_vld_q, s1_vld_d;
    logic                    s1_sign_q, s1_sign_d;
    logic [EXPONENTBITS-1:0] s1_exp_q, s1_exp_d;
    logic [MANTISSABITS-1:0] s1_man_q, s1_man_d;
    logic                    s1_daz_q, s1_daz_d;

    logic       s2_vld_q, s2_vld_d;
    logic       s2_sign_q, s2_sign_d;
    logic [5:0] s2_cls_q, s2_cls_d;
    logic       s2_zero_q, s2_zero_d;
    logic       s2_norm_q, s2_norm_d;
    logic       s2_exc_q, s2_exc_d;
    logic       s2_rawsub_q, s2_rawsub_d;

    logic               f_inv_q, f_inv_d;
    logic               f_inf_q, f_inf_d;
    logic               f_den_q, f_den_d;
    logic [CNTBITS-1:0] cnt_q, cnt_d;

    logic accept, xfer, s2_load;
    logic [5:0] s1_cls;
    logic s1_rawsub;

    assign InReady = ~Rst & (~s1_vld_q | ~s2_vld_q | OutReady);
    assign accept  = InValid & InReady;
    assign s2_load = ~s2_vld_q | OutReady;
    assign xfer    = s2_vld_q & OutReady;

    assign s1_cls    = classify(s1_exp_q, s1_man_q, s1_daz_q);
    assign s1_rawsub = (s1_exp_q == '0) && (s1_man_q != '0);

    // Stage 1: capture the raw fields on accept; drain when stage 2 takes the item.
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_sign_d = s1_sign_q;
        s1_exp_d  = s1_exp_q;
        s1_man_d  = s1_man_q;
        s1_daz_d  = s1_daz_q;
        if (accept) begin
            s1_vld_d  = 1'b1;
            s1_sign_d = InFloat[FLOATSIZE-1];
            s1_exp_d  = InFloat[FLOATSIZE-2 -: EXPONENTBITS];
            s1_man_d  = InFloat[MANTISSABITS-1:0];
            s1_daz_d  = InDaz;
        end else if (s2_load) begin
            s1_vld_d = 1'b0;
        end
    end

    // Stage 2: classified result, driven straight onto the output ports.
    always_comb begin
        s2_vld_d    = s2_vld_q;
        s2_sign_d   = s2_sign_q;
        s2_cls_d    = s2_cls_q;
        s2_zero_d   = s2_zero_q;
        s2_norm_d   = s2_norm_q;
        s2_exc_d    = s2_exc_q;
        s2_rawsub_d = s2_rawsub_q;
        if (s2_load) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_sign_d   = s1_sign_q;
                s2_cls_d    = s1_cls;
                s2_zero_d   = s1_cls[0] | s1_cls[3] | s1_cls[4] | s1_cls[5];
                s2_exc_d    = s1_cls[3] | s1_cls[4] | s1_cls[5];
                s2_norm_d   = ~(s1_rawsub & ~s1_daz_q);
                s2_rawsub_d = s1_rawsub;
            end
        end
    end

    // Clear is applied first so a coincident setting transfer wins.
    always_comb begin
        f_inv_d = FlagClr ? 1'b0 : f_inv_q;
        f_inf_d = FlagClr ? 1'b0 : f_inf_q;
        f_den_d = FlagClr ? 1'b0 : f_den_q;
        cnt_d   = FlagClr ? '0 : cnt_q;
        if (xfer) begin
            if (s2_cls_q[5]) f_inv_d = 1'b1;
            if (s2_cls_q[3]) f_inf_d = 1'b1;
            if (s2_rawsub_q) f_den_d = 1'b1;
            if (s2_exc_q)    cnt_d   = sat_inc(cnt_d);
        end
    end

    always_ff @(posedge Clk) begin
        s1_sign_q <= s1_sign_d;
        s1_exp_q  <= s1_exp_d;
        s1_man_q  <= s1_man_d;
        s1_daz_q  <= s1_daz_d;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_cls_q    <= '0;
            s2_zero_q   <= 1'b0;
            s2_norm_q   <= 1'b0;
            s2_exc_q    <= 1'b0;
            s2_rawsub_q <= 1'b0;
            f_inv_q     <= 1'b0;
            f_inf_q     <= 1'b0;
            f_den_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s2_vld_q    <= s2_vld_d;
            s2_sign_q   <= s2_sign_d;
            s2_cls_q    <= s2_cls_d;
            s2_zero_q   <= s2_zero_d;
            s2_norm_q   <= s2_norm_d;
            s2_exc_q    <= s2_exc_d;
            s2_rawsub_q <= s2_rawsub_d;
            f_inv_q     <= f_inv_d;
            f_inf_q     <= f_inf_d;
            f_den_q     <= f_den_d;
            cnt_q       <= cnt_d;
        end
    end

    assign OutValid     = s2_vld_q;
    assign OutSign      = s2_sign_q;
    assign OutClass     = s2_cls_q;
    assign OutZero      = s2_zero_q;
    assign OutNormal    = s2_norm_q;
    assign OutException = s2_exc_q;
    assign FlagInvalid  = f_inv_q;
    assign FlagInf      = f_inf_q;
    assign FlagDenorm   = f_den_q;
    assign ExcCount     = cnt_q;

endmodule

// File: tb/tb_float_class_pipe.sv
// Directed bench for float_class_pipe: scoreboard of expected classes filled on
// accept and drained on transfer, plus flag/counter checks between phases.
module tb_float_class_pipe;

    localparam int EB = 8;
    localparam int MB = 23;
    localparam int FS = EB + MB + 1;
    localparam int CB = 2;

    typedef struct packed {
        logic        sign;
        logic [5:0]  cls;
        logic [31:0] acc;
        logic        lat;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Rst, InValid, InReady, InDaz, OutValid, OutReady;
    logic [FS-1:0] InFloat;
    logic          OutSign, OutZero, OutNormal, OutException;
    logic [5:0]    OutClass;
    logic          FlagClr, FlagInvalid, FlagInf, FlagDenorm;
    logic [CB-1:0] ExcCount;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t sb[$];
    logic [5:0] cur_cls = '0;
    bit   lat_mode = 1'b0;
    bit   clr_on_xfer = 1'b0;
    bit   acc_b;

    float_class_pipe #(.EXPONENTBITS(EB), .MANTISSABITS(MB), .CNTBITS(CB)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
        .InFloat(InFloat), .InDaz(InDaz), .OutValid(OutValid), .OutReady(OutReady),
        .OutSign(OutSign), .OutClass(OutClass), .OutZero(OutZero),
        .OutNormal(OutNormal), .OutException(OutException), .FlagClr(FlagClr),
        .FlagInvalid(FlagInvalid), .FlagInf(FlagInf), .FlagDenorm(FlagDenorm),
        .ExcCount(ExcCount)
    );

    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: settle, evaluate handshakes as the coming edge will see them, then advance.
    task automatic cycle(output bit acc);
        exp_t e;
        bit   fired;
        fired = 1'b0;
        #1;
        acc = (InValid === 1'b1) && (InReady === 1'b1);
        if (acc) begin
            e.sign = InFloat[FS-1];
            e.cls  = cur_cls;
            e.acc  = cyc;
            e.lat  = lat_mode;
            sb.push_back(e);
        end
        if ((OutValid === 1'b1) && (OutReady === 1'b1)) begin
            if (clr_on_xfer) begin
                FlagClr = 1'b1;
                fired   = 1'b1;
            end
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected_output: observed class 0x%0h expected no output", OutClass);
            end else begin
                e = sb.pop_front();
                chk("out_sign", OutSign, e.sign);
                chk("out_class", OutClass, e.cls);
                chk("out_zero", OutZero, e.cls[0] | e.cls[3] | e.cls[4] | e.cls[5]);
                chk("out_exception", OutException, e.cls[3] | e.cls[4] | e.cls[5]);
                chk("out_normal", OutNormal, !e.cls[1]);
                if (e.lat) chk("latency", cyc - e.acc, 2);
            end
        end
        @(posedge Clk);
        cyc++;
        @(negedge Clk);
        if (fired) begin
            FlagClr     = 1'b0;
            clr_on_xfer = 1'b0;
        end
    endtask

    task automatic send(input logic [FS-1:0] f, input logic d, input logic [5:0] cls);
        bit acc;
        InValid = 1'b1;
        InFloat = f;
        InDaz   = d;
        cur_cls = cls;
        for (int i = 0; i < 20; i++) begin
            cycle(acc);
            if (acc) return;
        end
        n_cmp++;
        n_err++;
        $error("FAIL accept_timeout: observed no accept expected accept within 20 cycles");
        InValid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        InValid = 1'b0;
        repeat (n) cycle(acc);
    endtask

    initial begin
        Rst = 1'b1; InValid = 1'b0; InFloat = '0; InDaz = 1'b0;
        OutReady = 1'b1; FlagClr = 1'b0;
        @(negedge Clk);
        idle(2);

        chk("rst_inready", InReady, 0);
        chk("rst_outvalid", OutValid, 0);
        chk("rst_outs", {OutSign, OutClass, OutZero, OutNormal, OutException}, 0);
        chk("rst_flags", {FlagInvalid, FlagInf, FlagDenorm}, 0);
        chk("rst_count", ExcCount, 0);
        Rst = 1'b0;
        #1;
        chk("inready_after_rst", InReady, 1);

        // Back-to-back basic classes with latency check.
        lat_mode = 1'b1;
        send(32'h00000000, 1'b0, 6'h01);
        send(32'h3F800000, 1'b0, 6'h04);
        send(32'h80000001, 1'b0, 6'h02);
        send(32'h7F800000, 1'b0, 6'h08);
        lat_mode = 1'b0;
        idle(3);
        chk("t1_flags", {FlagInvalid, FlagInf, FlagDenorm}, 3'b011);
        chk("t1_count", ExcCount, 1);
        chk("t1_drained", sb.size(), 0);

        // NaNs after clearing the sticky state.
        FlagClr = 1'b1;
        idle(1);
        FlagClr = 1'b0;
        chk("clr_flags", {FlagInvalid, FlagInf, FlagDenorm}, 0);
        chk("clr_count", ExcCount, 0);
        send(32'h7FC00000, 1'b0, 6'h10);
        idle(3);
        chk("qnan_invalid", FlagInvalid, 0);
        chk("qnan_count", ExcCount, 1);
        send(32'h7F800001, 1'b0, 6'h20);
        idle(3);
        chk("snan_invalid", FlagInvalid, 1);
        chk("snan_count", ExcCount, 2);

        // Denormals with and without DAZ.
        chk("daz_pre_denorm", FlagDenorm, 0);
        send(32'h00400000, 1'b1, 6'h01);
        idle(3);
        chk("daz_denorm", FlagDenorm, 1);
        send(32'h00400000, 1'b0, 6'h02);
        idle(3);

        // Backpressure: two items fill the pipe, the third is refused.
        OutReady = 1'b0;
        send(32'h3F800000, 1'b0, 6'h04);
        send(32'h80000000, 1'b0, 6'h01);
        InValid = 1'b1; InFloat = 32'h00000001; InDaz = 1'b0; cur_cls = 6'h02;
        repeat (3) begin
            cycle(acc_b);
            chk("stall_accept", acc_b, 0);
            chk("stall_inready", InReady, 0);
            chk("stall_outvalid", OutValid, 1);
            chk("stall_class", OutClass, 6'h04);
            chk("stall_sign", OutSign, 0);
        end
        OutReady = 1'b1;
        send(32'h00000001, 1'b0, 6'h02);
        send(32'hBF800000, 1'b0, 6'h04);
        idle(4);
        chk("stall_drained", sb.size(), 0);

        // Counter saturation, then clear coinciding with an exception transfer.
        FlagClr = 1'b1;
        idle(1);
        FlagClr = 1'b0;
        repeat (5) send(32'h7F800000, 1'b0, 6'h08);
        idle(3);
        chk("sat_count", ExcCount, 3);
        chk("sat_inf", FlagInf, 1);
        clr_on_xfer = 1'b1;
        send(32'hFF800000, 1'b0, 6'h08);
        idle(3);
        chk("clr_set_count", ExcCount, 1);
        chk("clr_set_flags", {FlagInvalid, FlagInf, FlagDenorm}, 3'b010);
        chk("clr_set_fired", clr_on_xfer, 0);

        // Reset with two items in flight.
        OutReady = 1'b0;
        send(32'h7F800000, 1'b0, 6'h08);
        send(32'h00000001, 1'b0, 6'h02);
        Rst = 1'b1;
        idle(1);
        chk("midrst_outvalid", OutValid, 0);
        chk("midrst_flags", {FlagInvalid, FlagInf, FlagDenorm}, 0);
        chk("midrst_count", ExcCount, 0);
        sb.delete();
        Rst = 1'b0;
        OutReady = 1'b1;
        idle(5);
        chk("post_rst_outvalid", OutValid, 0);
        chk("post_rst_flags", {FlagInvalid, FlagInf, FlagDenorm}, 0);
        chk("post_rst_count", ExcCount, 0);
        chk("post_rst_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
